// File: rtl/axis_nibble_unpacker.sv
// Nibble unpacker: re-emits packed 16-bit AXI-stream words as beats of N nibbles.
// Ports: clk, rst (async low), s_* slave stream, cfg_nib, m_* master stream, err; UNPACK_STATS_EN adds pkt_cnt/nib_cnt.
module axis_nibble_unpacker #(
  parameter int DEPTH = 32,
  parameter int AW    = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] s_data,
  input  logic        s_valid,
  input  logic        s_last,
  input  logic [7:0]  s_keep,
  output logic        s_ready,
  input  logic [2:0]  cfg_nib,
  output logic [15:0] m_data,
  output logic        m_valid,
  output logic        m_last,
  output logic [7:0]  m_keep,
  input  logic        m_ready,
  output logic        err
`ifdef UNPACK_STATS_EN
  ,
  output logic [15:0] pkt_cnt,
  output logic [15:0] nib_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    DRAIN
  } state_t;

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  state_t      state;
  logic [3:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0] count;
  logic [AW:0] free;
  logic [2:0]  n_q;
  logic [2:0]  n_cfg;
  logic        last_sent;

  logic        accept;
  logic        keep_ok;
  logic [2:0]  push;
  logic        m_hs;
  logic        slot;
  logic        form;
  logic [2:0]  e;
  logic        last_b;
  logic [AW:0] n_ext;
  logic [15:0] d_next;

  assign n_cfg   = (cfg_nib == 3'd0 || cfg_nib > 3'd4) ? 3'd4 : cfg_nib;
  assign free    = DEPTH_C - count;
  // Gated by rst so every output reads 0 while reset is held.
  assign s_ready = rst && (state != DRAIN) && (free >= (AW+1)'(4));
  assign accept  = s_valid && s_ready;
  assign keep_ok = s_keep inside {8'd0, 8'd4, 8'd8, 8'd12, 8'd16};
  assign push    = keep_ok ? s_keep[4:2] : 3'd0;
  assign m_hs    = m_valid && m_ready;
  assign slot    = !m_valid || m_hs;

  always_comb begin
    n_ext  = (AW+1)'(n_q);
    e      = (count >= n_ext) ? n_q : count[2:0];
    form   = 1'b0;
    if (slot) begin
      unique case (1'b1)
        (state == FILL):  form = (count >= n_ext);
        // Also covers the empty final beat of a zero-length packet.
        (state == DRAIN): form = (count != '0) || !last_sent;
        default:          form = 1'b0;
      endcase
    end
    last_b = (state == DRAIN) && ((AW+1)'(e) == count);
    d_next = '0;
    for (int i = 0; i < 4; i++) begin
      if (3'(i) < e)
        d_next[4*i +: 4] = mem[rd_ptr + AW'(i)];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      n_q       <= 3'd0;
      last_sent <= 1'b0;
      err       <= 1'b0;
      m_data    <= '0;
      m_valid   <= 1'b0;
      m_last    <= 1'b0;
      m_keep    <= '0;
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= 4'h0;
    end else begin
      if (accept) begin
        for (int k = 0; k < 4; k++) begin
          if (3'(k) < push)
            mem[wr_ptr + AW'(k)] <= s_data[4*k +: 4];
        end
        wr_ptr <= wr_ptr + AW'(push);
        if (!keep_ok)
          err <= 1'b1;
      end

      unique case (state)
        IDLE: begin
          if (accept) begin
            n_q       <= n_cfg;
            last_sent <= 1'b0;
            state     <= s_last ? DRAIN : FILL;
          end
        end
        FILL: begin
          if (accept && s_last) begin
            last_sent <= 1'b0;
            state     <= DRAIN;
          end
        end
        DRAIN: begin
          if (m_hs && m_last)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      if (form) begin
        m_valid <= 1'b1;
        m_data  <= d_next;
        m_keep  <= {3'b000, e, 2'b00};
        m_last  <= last_b;
        rd_ptr  <= rd_ptr + AW'(e);
        if (last_b)
          last_sent <= 1'b1;
      end else if (m_hs) begin
        m_valid <= 1'b0;
        m_data  <= '0;
        m_keep  <= '0;
        m_last  <= 1'b0;
      end

      count <= count
             + (accept ? (AW+1)'(push) : '0)
             - (form ? (AW+1)'(e) : '0);
    end
  end

`ifdef UNPACK_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pkt_cnt <= '0;
      nib_cnt <= '0;
    end else if (m_hs) begin
      nib_cnt <= nib_cnt + {13'd0, m_keep[4:2]};
      if (m_last)
        pkt_cnt <= pkt_cnt + 16'd1;
    end
  end
`endif

endmodule
